// File: rtl/hpm_sample_dumper.sv
// hpm_sample_dumper: periodically sweeps mhpmcounter3.. over the shared CSR read port into a FWFT sample FIFO.
// Optional HPM_SAMPLE_TIMESTAMP_EN: each sweep starts with a 64-bit cycle-count entry tagged idx 31.

module hpm_sample_dumper #(
  parameter int NUM_COUNTERS  = 29,
  parameter int FIFO_DEPTH    = 8,
  parameter int PERIOD_W      = 32,
  parameter int SEQ_W         = 8,
  parameter int CSR_ADDR_SIZE = 12,
  parameter logic [CSR_ADDR_SIZE-1:0] CSR_MHPM_COUNTER_3 = 'hB03
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [PERIOD_W-1:0]      period_i,
  input  logic                     grant_i,
  output logic                     req_o,
  output logic [CSR_ADDR_SIZE-1:0] addr_o,
  output logic                     we_o,
  input  logic [63:0]              data_i,
  output logic                     smp_valid_o,
  input  logic                     smp_ready_i,
  output logic [63:0]              smp_data_o,
  output logic [4:0]               smp_idx_o,
  output logic [SEQ_W-1:0]         smp_seq_o,
  output logic                     overrun_o,
  output logic                     busy_o
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 64 + 5 + SEQ_W;
  localparam logic [4:0] LAST_IDX = 5'(NUM_COUNTERS - 1);

`ifdef HPM_SAMPLE_TIMESTAMP_EN
  localparam logic [4:0] TS_IDX = 5'd31;
  typedef enum logic [1:0] {IDLE, TSTAMP, SWEEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SWEEP} state_t;
`endif

  state_t               state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [PERIOD_W-1:0]  timer_q;
  logic                 enable_q;
  logic                 timer_run, tick;

  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [PTR_W:0]       count_q;
  logic                 full, empty, push, pop, can_push;
  logic [ENTRY_W-1:0]   push_entry;

  // The >= compare makes a period shortened below the running count wrap immediately.
  assign timer_run = enable_i && (period_i != '0);
  assign tick      = timer_run && (timer_q >= period_i - PERIOD_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q   <= '0;
      enable_q  <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      enable_q <= enable_i;
      if (!timer_run || tick) timer_q <= '0;
      else                    timer_q <= timer_q + PERIOD_W'(1);
      if (enable_i && !enable_q)         overrun_o <= 1'b0;
      else if (tick && state_q != IDLE)  overrun_o <= 1'b1;
    end
  end

`ifdef HPM_SAMPLE_TIMESTAMP_EN
  logic [63:0] cycle_q, stamp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_q <= '0;
      stamp_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (tick && state_q == IDLE) stamp_q <= cycle_q;
    end
  end
`endif

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop      = !empty && smp_ready_i;
  assign can_push = !full || pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    req_o      = 1'b0;
    addr_o     = '0;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          idx_d = '0;
`ifdef HPM_SAMPLE_TIMESTAMP_EN
          state_d = TSTAMP;
`else
          state_d = SWEEP;
`endif
        end
      end
`ifdef HPM_SAMPLE_TIMESTAMP_EN
      TSTAMP: begin
        if (can_push) begin
          push       = 1'b1;
          push_entry = {stamp_q, TS_IDX, seq_q};
          state_d    = SWEEP;
        end
      end
`endif
      SWEEP: begin
        req_o  = 1'b1;
        addr_o = CSR_MHPM_COUNTER_3 + CSR_ADDR_SIZE'(idx_q);
        if (grant_i && can_push) begin
          push       = 1'b1;
          push_entry = {data_i, idx_q, seq_q};
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            seq_d   = seq_q + SEQ_W'(1);
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the read side is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= push_entry;
  end

  assign smp_valid_o = !empty;
  assign {smp_data_o, smp_idx_o, smp_seq_o} = smp_valid_o ? mem[rptr_q] : '0;
  assign we_o   = 1'b0;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_hpm_sample_dumper.sv
// tb_hpm_sample_dumper: directed scenarios for hpm_sample_dumper with hand-computed expectations.
// Counter read data is modelled as {32'hDEADBEEF, 20'h0, addr}, so every entry names its own address.

module tb_hpm_sample_dumper;

  logic        clk_i = 1'b0;
  logic        rst_i, enable_i, grant_i, smp_ready_i;
  logic [31:0] period_i;
  logic        req_o, we_o, smp_valid_o, overrun_o, busy_o;
  logic [11:0] addr_o;
  logic [63:0] data_i, smp_data_o;
  logic [4:0]  smp_idx_o;
  logic [7:0]  smp_seq_o;

  int errors = 0;
  int checks = 0;

  logic [63:0] q_data[$];
  logic [4:0]  q_idx[$];
  logic [7:0]  q_seq[$];

  hpm_sample_dumper dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .period_i(period_i),
    .grant_i(grant_i), .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .data_i(data_i),
    .smp_valid_o(smp_valid_o), .smp_ready_i(smp_ready_i), .smp_data_o(smp_data_o),
    .smp_idx_o(smp_idx_o), .smp_seq_o(smp_seq_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  assign data_i = {32'hDEAD_BEEF, 20'h0, addr_o};

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] exp_data(int i);
    return {32'hDEAD_BEEF, 20'h0, 12'hB03 + 12'(i)};
  endfunction

  // Records the head entry if it pops on the coming edge, then advances one cycle.
  task automatic step();
    if (smp_valid_o && smp_ready_i) begin
      q_data.push_back(smp_data_o);
      q_idx.push_back(smp_idx_o);
      q_seq.push_back(smp_seq_o);
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; enable_i = 1'b0; period_i = '0; grant_i = 1'b0; smp_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    q_data.delete(); q_idx.delete(); q_seq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (smp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", smp_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (req_o !== 1'b0 || addr_o !== 12'h0) begin errors++; $display("[TB] FAIL reset_req: got req=%b addr=%h want 0/000", req_o, addr_o); end
    checks++; if (overrun_o !== 1'b0 || we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got ovr=%b we=%b want 0/0", overrun_o, we_o); end
    period_i = 32'd3;
    for (int i = 0; i < 10; i++) step();
    checks++; if (busy_o !== 1'b0 || smp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL disabled_idle: got busy=%b valid=%b want 0/0", busy_o, smp_valid_o); end
  endtask

  task automatic test_sweep();
    do_reset();
    period_i = 32'd100; enable_i = 1'b1; grant_i = 1'b1; smp_ready_i = 1'b1;
    for (int i = 0; i < 99; i++) step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL pre_tick_busy: got %b want 0", busy_o); end
    step();
    checks++; if (busy_o !== 1'b1 || req_o !== 1'b1 || addr_o !== 12'hB03) begin
      errors++; $display("[TB] FAIL first_req: got busy=%b req=%b addr=%h want 1/1/b03", busy_o, req_o, addr_o); end
    step();
    checks++; if (smp_valid_o !== 1'b1 || smp_idx_o !== 5'd0 || smp_data_o !== exp_data(0)) begin
      errors++; $display("[TB] FAIL first_sample: got valid=%b idx=%0d data=%h want 1/0/%h", smp_valid_o, smp_idx_o, smp_data_o, exp_data(0)); end
    for (int i = 0; i < 139; i++) step();
    checks++; if (q_idx.size() !== 58) begin errors++; $display("[TB] FAIL sweep_count: got %0d want 58", q_idx.size()); end
    for (int i = 0; i < q_idx.size(); i++) begin
      checks++;
      if (q_idx[i] !== 5'(i % 29) || q_seq[i] !== 8'(i / 29) || q_data[i] !== exp_data(i % 29)) begin
        errors++; $display("[TB] FAIL sweep_entry[%0d]: got idx=%0d seq=%0d data=%h want idx=%0d seq=%0d data=%h",
          i, q_idx[i], q_seq[i], q_data[i], i % 29, i / 29, exp_data(i % 29)); end
    end
    checks++; if (busy_o !== 1'b0 || overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL sweep_end: got busy=%b ovr=%b want 0/0", busy_o, overrun_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    period_i = 32'd100; enable_i = 1'b1; grant_i = 1'b1; smp_ready_i = 1'b0;
    for (int i = 0; i < 100; i++) step();
    enable_i = 1'b0;
    for (int i = 0; i < 30; i++) step();
    checks++; if (req_o !== 1'b1 || addr_o !== 12'hB0B || busy_o !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_hold: got req=%b addr=%h busy=%b want 1/b0b/1", req_o, addr_o, busy_o); end
    checks++; if (smp_valid_o !== 1'b1 || smp_idx_o !== 5'd0 || smp_data_o !== exp_data(0)) begin
      errors++; $display("[TB] FAIL stall_head: got valid=%b idx=%0d data=%h want 1/0/%h", smp_valid_o, smp_idx_o, smp_data_o, exp_data(0)); end
    smp_ready_i = 1'b1;
    for (int i = 0; i < 60; i++) step();
    checks++; if (q_idx.size() !== 29) begin errors++; $display("[TB] FAIL drain_count: got %0d want 29", q_idx.size()); end
    for (int i = 0; i < q_idx.size(); i++) begin
      checks++;
      if (q_idx[i] !== 5'(i) || q_seq[i] !== 8'd0 || q_data[i] !== exp_data(i)) begin
        errors++; $display("[TB] FAIL drain_entry[%0d]: got idx=%0d seq=%0d data=%h want idx=%0d seq=0 data=%h",
          i, q_idx[i], q_seq[i], q_data[i], i, exp_data(i)); end
    end
    checks++; if (busy_o !== 1'b0 || smp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL drain_end: got busy=%b valid=%b want 0/0", busy_o, smp_valid_o); end
  endtask

  task automatic test_grant_throttle();
    int n;
    int granted;
    do_reset();
    period_i = 32'd100; enable_i = 1'b1; grant_i = 1'b0; smp_ready_i = 1'b1;
    n = 0;
    while (!busy_o && n < 150) begin step(); n++; end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL throttle_start: got busy=%b want 1", busy_o); end
    enable_i = 1'b0;
    granted = 0;
    n = 0;
    while (busy_o && n < 200) begin
      checks++;
      if (addr_o !== 12'hB03 + 12'(granted)) begin
        errors++; $display("[TB] FAIL throttle_addr: got %h want %h at step %0d", addr_o, 12'hB03 + 12'(granted), n); end
      grant_i = (n % 3 == 0);
      step();
      if (grant_i) granted++;
      n++;
    end
    grant_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (granted !== 29 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL throttle_grants: got %0d busy=%b want 29/0", granted, busy_o); end
    checks++; if (q_idx.size() !== 29) begin errors++; $display("[TB] FAIL throttle_count: got %0d want 29", q_idx.size()); end
    for (int i = 0; i < q_idx.size(); i++) begin
      checks++;
      if (q_idx[i] !== 5'(i) || q_data[i] !== exp_data(i)) begin
        errors++; $display("[TB] FAIL throttle_entry[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i, q_idx[i], q_data[i], i, exp_data(i)); end
    end
  endtask

  task automatic test_overrun();
    int n;
    do_reset();
    period_i = 32'd10; enable_i = 1'b1; grant_i = 1'b1; smp_ready_i = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL overrun_early: got %b want 0", overrun_o); end
    for (int i = 0; i < 10; i++) step();
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b want 1", overrun_o); end
    for (int i = 0; i < 75; i++) step();
    enable_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin step(); n++; end
    for (int i = 0; i < 3; i++) step();
    checks++; if (q_idx.size() !== 116) begin errors++; $display("[TB] FAIL overrun_count: got %0d want 116", q_idx.size()); end
    for (int i = 0; i < q_idx.size(); i++) begin
      checks++;
      if (q_idx[i] !== 5'(i % 29) || q_seq[i] !== 8'(i / 29)) begin
        errors++; $display("[TB] FAIL overrun_entry[%0d]: got idx=%0d seq=%0d want idx=%0d seq=%0d", i, q_idx[i], q_seq[i], i % 29, i / 29); end
    end
    checks++; if (overrun_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL overrun_sticky: got ovr=%b busy=%b want 1/0", overrun_o, busy_o); end
    period_i = 32'd0; enable_i = 1'b1;
    step();
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear: got %b want 0", overrun_o); end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    period_i = 32'd40; enable_i = 1'b1; grant_i = 1'b1; smp_ready_i = 1'b1;
    for (int i = 0; i < 89; i++) step();
    smp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (q_idx.size() !== 37) begin errors++; $display("[TB] FAIL mid_collected: got %0d want 37", q_idx.size()); end
    checks++; if (q_idx.size() == 37 && (q_seq[29] !== 8'd1 || q_idx[36] !== 5'd7)) begin
      errors++; $display("[TB] FAIL mid_second_seq: got seq=%0d idx=%0d want 1/7", q_seq[29], q_idx[36]); end
    checks++; if (addr_o !== 12'hB0F || smp_valid_o !== 1'b1 || smp_idx_o !== 5'd8 || smp_seq_o !== 8'd1) begin
      errors++; $display("[TB] FAIL mid_state: got addr=%h valid=%b idx=%0d seq=%0d want b0f/1/8/1", addr_o, smp_valid_o, smp_idx_o, smp_seq_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (smp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset: got valid=%b busy=%b req=%b ovr=%b want 0/0/0/0", smp_valid_o, busy_o, req_o, overrun_o); end
    @(negedge clk_i);
    rst_i = 1'b0; smp_ready_i = 1'b1;
    q_data.delete(); q_idx.delete(); q_seq.delete();
    for (int i = 0; i < 45; i++) step();
    checks++; if (q_idx.size() < 1) begin errors++; $display("[TB] FAIL post_reset_count: got %0d want >=1", q_idx.size()); end
    else if (q_seq[0] !== 8'd0 || q_idx[0] !== 5'd0) begin
      checks++; errors++; $display("[TB] FAIL post_reset_seq: got seq=%0d idx=%0d want 0/0", q_seq[0], q_idx[0]); end
  endtask

`ifdef HPM_SAMPLE_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    period_i = 32'd50; enable_i = 1'b1; grant_i = 1'b1; smp_ready_i = 1'b1;
    for (int i = 0; i < 140; i++) step();
    checks++; if (q_idx.size() !== 60) begin errors++; $display("[TB] FAIL ts_count: got %0d want 60", q_idx.size()); end
    else begin
      checks++; if (q_idx[0] !== 5'd31 || q_data[0] !== 64'd49 || q_seq[0] !== 8'd0) begin
        errors++; $display("[TB] FAIL ts_first: got idx=%0d data=%0d seq=%0d want 31/49/0", q_idx[0], q_data[0], q_seq[0]); end
      checks++; if (q_idx[30] !== 5'd31 || q_data[30] - q_data[0] !== 64'd50 || q_seq[30] !== 8'd1) begin
        errors++; $display("[TB] FAIL ts_second: got idx=%0d delta=%0d seq=%0d want 31/50/1", q_idx[30], q_data[30] - q_data[0], q_seq[30]); end
      checks++; if (q_idx[1] !== 5'd0 || q_idx[29] !== 5'd28 || q_data[29] !== exp_data(28)) begin
        errors++; $display("[TB] FAIL ts_body: got idx=%0d/%0d data=%h want 0/28/%h", q_idx[1], q_idx[29], q_data[29], exp_data(28)); end
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; period_i = '0; grant_i = 1'b0; smp_ready_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_sweep();
    test_backpressure();
    test_grant_throttle();
    test_overrun();
    test_reset_mid_sweep();
`ifdef HPM_SAMPLE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
